uart_cmd_decoder: RTL and testbench
===================================

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning the maximum number of clock cycles allowed between the first and second byte of a frame.
REQ-002 The block SHALL have parameter MAX_ADDRESS, default 8'h1F, meaning the highest legal address byte.
REQ-003 The block SHALL have parameter MAX_COMMAND, default 8'h07, meaning the highest legal command byte.
REQ-004 The block SHALL have port: clock  input  1  single clock, shared with the receiver stage.
REQ-005 The block SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port: has_data  input  1  one-cycle strobe marking a received byte.
REQ-007 The block SHALL have port: data_received  input  8  received byte, valid while has_data is high.
REQ-008 The block SHALL have port: command  output  8  command byte of the last valid frame.
REQ-009 The block SHALL have port: address  output  8  address byte of the last valid frame.
REQ-010 The block SHALL have port: command_valid  output  1  one-cycle pulse marking a new valid frame.
REQ-011 The block SHALL have port: frame_error  output  1  one-cycle pulse marking a rejected or timed-out frame.
REQ-012 The block SHALL have port: busy  output  1  high while a frame is partially received.

Function
REQ-013 A frame SHALL be two bytes: byte 0 is the command and byte 1 is the address.
REQ-014 The FSM SHALL have two states: IDLE and WAIT_ADDR.
- IDLE -> WAIT_ADDR on has_data; byte 0 is latched into an internal holding register.
- WAIT_ADDR -> IDLE on has_data or on timeout.
REQ-015 busy SHALL equal (state == WAIT_ADDR).
REQ-016 On has_data in WAIT_ADDR, if the held command <= MAX_COMMAND and data_received <= MAX_ADDRESS:
- command and address SHALL update at that edge;
- command_valid SHALL be high for exactly the following cycle (latency 1 cycle after the has_data cycle).
REQ-017 On has_data in WAIT_ADDR with an out-of-range command or address:
- command and address SHALL hold their previous values;
- frame_error SHALL pulse for one cycle with the same latency as command_valid.
REQ-018 command and address SHALL hold their values between valid frames.
REQ-019 command_valid and frame_error SHALL never be high in the same cycle.
REQ-020 has_data asserted in the same cycle as command_valid or frame_error SHALL be accepted as byte 0 of a new frame; no byte SHALL be lost.
REQ-021 has_data held high for N consecutive cycles SHALL be treated as N bytes.
REQ-022 All range comparisons SHALL be unsigned, 8-bit.

Reset
REQ-023 Reset SHALL force, asynchronously, the following values:
- state = IDLE;
- command = 8'h00 and address = 8'h00;
- command_valid = 0, frame_error = 0, busy = 0;
- timeout counter = 0.
REQ-024 Reset asserted mid-frame SHALL discard the held byte; the first has_data after release SHALL be treated as byte 0.

Configuration
REQ-025 With macro CMD_TIMEOUT_EN defined, timeout behaviour SHALL be as follows:
- a counter, sized $clog2(TIMEOUT_CYCLES)+1 bits, SHALL clear on entry to WAIT_ADDR and increment each WAIT_ADDR cycle without has_data;
- when the counter reaches TIMEOUT_CYCLES-1, the FSM SHALL return to IDLE and frame_error SHALL pulse once;
- has_data in the expiry cycle SHALL win, completing the frame with no error.
REQ-026 Without CMD_TIMEOUT_EN:
- no counter SHALL be instantiated;
- WAIT_ADDR SHALL persist indefinitely until the second byte arrives or reset is asserted.

Verification
REQ-027 Bytes 0x03 then 0x10, 5 cycles apart -> command_valid pulse 1 cycle after the second strobe; command=0x03, address=0x10; frame_error stays 0.
REQ-028 Bytes 0x09 then 0x02 -> frame_error pulse; command and address keep their prior values; command_valid stays 0.
REQ-029 With CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16: byte 0x01 then idle -> frame_error pulses once, busy drops; next bytes 0x02, 0x04 -> valid frame with command=0x02, address=0x04.
REQ-030 Back-to-back strobes 0x01, 0x05, 0x02, 0x06 on consecutive cycles -> two command_valid pulses, giving (0x01,0x05) then (0x02,0x06).
REQ-031 Reset asserted while busy=1 after byte 0x04, released, then bytes 0x05, 0x01 -> exactly one frame, command=0x05, address=0x01.
REQ-032 With CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16: second byte arrives exactly in the expiry cycle -> command_valid=1, frame_error=0.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - two-byte UART command/address frame decoder
//
// Purpose: assembles {command, address} frames from a byte-strobe stream,
// range-checks both bytes and reports a one-cycle valid or error pulse.
// Optional inter-byte timeout is enabled by defining macro CMD_TIMEOUT_EN.
//
// Ports:
//   clock          in   1  single clock shared with the receiver stage
//   reset          in   1  asynchronous active-high reset
//   has_data       in   1  one-cycle strobe per received byte
//   data_received  in   8  received byte, valid while has_data is high
//   command        out  8  command byte of the last valid frame
//   address        out  8  address byte of the last valid frame
//   command_valid  out  1  one-cycle pulse for a new valid frame
//   frame_error    out  1  one-cycle pulse for a rejected or timed-out frame
//   busy           out  1  high while a frame is partially received

module uart_cmd_decoder #(
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] MAX_ADDRESS    = 8'h1F,
    parameter logic [7:0] MAX_COMMAND    = 8'h07
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       has_data,
    input  logic [7:0] data_received,
    output logic [7:0] command,
    output logic [7:0] address,
    output logic       command_valid,
    output logic       frame_error,
    output logic       busy
);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_ADDR = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] r_held_cmd;
    logic       w_frame_ok;

    // Unsigned 8-bit compares: both operands are plain logic vectors.
    assign w_frame_ok = (r_held_cmd <= MAX_COMMAND) && (data_received <= MAX_ADDRESS);
    assign busy       = (r_state == WAIT_ADDR);

`ifdef CMD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_timeout_cnt;
    logic             w_expired;

    assign w_expired = (r_timeout_cnt == LAST_CNT);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_held_cmd    <= 8'h00;
            command       <= 8'h00;
            address       <= 8'h00;
            command_valid <= 1'b0;
            frame_error   <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            r_timeout_cnt <= '0;
`endif
        end else begin
            // Pulses default low; at most one of them is set below.
            command_valid <= 1'b0;
            frame_error   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (has_data) begin
                        r_held_cmd <= data_received;
                        r_state    <= WAIT_ADDR;
`ifdef CMD_TIMEOUT_EN
                        r_timeout_cnt <= '0;
`endif
                    end
                end
                WAIT_ADDR: begin
                    // A byte in the expiry cycle takes priority over the timeout.
                    if (has_data) begin
                        r_state <= IDLE;
                        if (w_frame_ok) begin
                            command       <= r_held_cmd;
                            address       <= data_received;
                            command_valid <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
`ifdef CMD_TIMEOUT_EN
                    end else if (w_expired) begin
                        r_state     <= IDLE;
                        frame_error <= 1'b1;
                    end else begin
                        r_timeout_cnt <= r_timeout_cnt + 1'b1;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb/tb_uart_cmd_decoder.sv - self-checking bench for uart_cmd_decoder

module tb_uart_cmd_decoder;

    logic       clock = 1'b0;
    logic       reset;
    logic       has_data;
    logic [7:0] data_received;
    logic [7:0] command;
    logic [7:0] address;
    logic       command_valid;
    logic       frame_error;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    uart_cmd_decoder #(
        .TIMEOUT_CYCLES(16),
        .MAX_ADDRESS   (8'h1F),
        .MAX_COMMAND   (8'h07)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .has_data     (has_data),
        .data_received(data_received),
        .command      (command),
        .address      (address),
        .command_valid(command_valid),
        .frame_error  (frame_error),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       hd;
        logic [7:0] d;
        logic       cv;
        logic       fe;
        logic       bsy;
        logic [7:0] cmd;
        logic [7:0] addr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of input, sample outputs 1 time unit after the edge.
    task automatic step(input logic hd, input logic [7:0] d);
        has_data      = hd;
        data_received = d;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic cv, input logic fe, input logic bsy,
                           input logic [7:0] cmd, input logic [7:0] addr);
        chk({tag, " command_valid"}, {7'd0, command_valid}, {7'd0, cv});
        chk({tag, " frame_error"},   {7'd0, frame_error},   {7'd0, fe});
        chk({tag, " busy"},          {7'd0, busy},          {7'd0, bsy});
        chk({tag, " command"},       command,               cmd);
        chk({tag, " address"},       address,               addr);
    endtask

    task automatic add(input logic hd, input logic [7:0] d, input logic cv, input logic fe,
                       input logic bsy, input logic [7:0] cmd, input logic [7:0] addr);
        vec_t v;
        v.hd = hd; v.d = d; v.cv = cv; v.fe = fe; v.bsy = bsy; v.cmd = cmd; v.addr = addr;
        vecs.push_back(v);
    endtask

    int cv_count;
    int fe_count;

    initial begin
        // Frame 0x03/0x10, strobes 5 cycles apart
        add(1, 8'h03, 0, 0, 1, 8'h00, 8'h00);
        add(0, 8'h00, 0, 0, 1, 8'h00, 8'h00);
        add(0, 8'h00, 0, 0, 1, 8'h00, 8'h00);
        add(0, 8'h00, 0, 0, 1, 8'h00, 8'h00);
        add(0, 8'h00, 0, 0, 1, 8'h00, 8'h00);
        add(1, 8'h10, 1, 0, 0, 8'h03, 8'h10);
        // Bad command 0x09, addr 0x02: error, outputs hold
        add(1, 8'h09, 0, 0, 1, 8'h03, 8'h10);
        add(1, 8'h02, 0, 1, 0, 8'h03, 8'h10);
        add(0, 8'h00, 0, 0, 0, 8'h03, 8'h10);
        // Back-to-back 0x01,0x05,0x02,0x06
        add(1, 8'h01, 0, 0, 1, 8'h03, 8'h10);
        add(1, 8'h05, 1, 0, 0, 8'h01, 8'h05);
        add(1, 8'h02, 0, 0, 1, 8'h01, 8'h05);
        add(1, 8'h06, 1, 0, 0, 8'h02, 8'h06);
        add(0, 8'h00, 0, 0, 0, 8'h02, 8'h06);
        // Boundaries: max legal, one past, all-ones, zero
        add(1, 8'h07, 0, 0, 1, 8'h02, 8'h06);
        add(1, 8'h1F, 1, 0, 0, 8'h07, 8'h1F);
        add(1, 8'h08, 0, 0, 1, 8'h07, 8'h1F);
        add(1, 8'h00, 0, 1, 0, 8'h07, 8'h1F);
        add(1, 8'h00, 0, 0, 1, 8'h07, 8'h1F);
        add(1, 8'h20, 0, 1, 0, 8'h07, 8'h1F);
        add(1, 8'hFF, 0, 0, 1, 8'h07, 8'h1F);
        add(1, 8'hFF, 0, 1, 0, 8'h07, 8'h1F);
        add(1, 8'h00, 0, 0, 1, 8'h07, 8'h1F);
        add(1, 8'h00, 1, 0, 0, 8'h00, 8'h00);
        add(0, 8'h00, 0, 0, 0, 8'h00, 8'h00);

        reset         = 1'b1;
        has_data      = 1'b0;
        data_received = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        chk_all("reset", 0, 0, 0, 8'h00, 8'h00);
        @(negedge clock);
        reset = 1'b0;
        #4;

        foreach (vecs[i]) begin
            step(vecs[i].hd, vecs[i].d);
            chk_all($sformatf("vec%0d", i), vecs[i].cv, vecs[i].fe, vecs[i].bsy,
                    vecs[i].cmd, vecs[i].addr);
        end

        // Set known outputs, then reset mid-frame after byte 0x04
        step(1, 8'h01);
        step(1, 8'h02);
        chk_all("pre_rst", 1, 0, 0, 8'h01, 8'h02);
        step(1, 8'h04);
        chk({"mid busy"}, {7'd0, busy}, 8'd1);
        has_data = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 8'h00, 8'h00);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #4;
        cv_count = 0;
        fe_count = 0;
        step(1, 8'h05);
        cv_count += command_valid; fe_count += frame_error;
        chk("rst byte0 busy", {7'd0, busy}, 8'd1);
        step(1, 8'h01);
        cv_count += command_valid; fe_count += frame_error;
        chk_all("rst frame", 1, 0, 0, 8'h05, 8'h01);
        repeat (3) begin
            step(0, 8'h00);
            cv_count += command_valid; fe_count += frame_error;
        end
        chk("rst cv count", 8'(cv_count), 8'd1);
        chk("rst fe count", 8'(fe_count), 8'd0);

`ifdef CMD_TIMEOUT_EN
        // Timeout: byte 0x01 then idle; error after the 16th idle edge
        step(1, 8'h01);
        fe_count = 0;
        for (int k = 0; k < 15; k++) begin
            step(0, 8'h00);
            fe_count += frame_error;
            if (busy !== 1'b1) chk($sformatf("to busy c%0d", k), {7'd0, busy}, 8'd1);
        end
        chk("to early fe", 8'(fe_count), 8'd0);
        step(0, 8'h00);
        chk_all("to expire", 0, 1, 0, 8'h05, 8'h01);
        step(0, 8'h00);
        chk_all("to after", 0, 0, 0, 8'h05, 8'h01);
        step(1, 8'h02);
        step(1, 8'h04);
        chk_all("to next frame", 1, 0, 0, 8'h02, 8'h04);
        // Second byte exactly in the expiry cycle wins
        step(1, 8'h03);
        repeat (15) step(0, 8'h00);
        chk("exp busy", {7'd0, busy}, 8'd1);
        step(1, 8'h10);
        chk_all("exp win", 1, 0, 0, 8'h03, 8'h10);
        step(0, 8'h00);
        chk_all("exp after", 0, 0, 0, 8'h03, 8'h10);
`else
        // No timeout: WAIT_ADDR persists over a long gap
        step(1, 8'h06);
        fe_count = 0;
        for (int k = 0; k < 40; k++) begin
            step(0, 8'h00);
            fe_count += frame_error;
        end
        chk("nto busy", {7'd0, busy}, 8'd1);
        chk("nto fe count", 8'(fe_count), 8'd0);
        step(1, 8'h11);
        chk_all("nto frame", 1, 0, 0, 8'h06, 8'h11);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Mutual exclusion of the two pulses, checked every cycle
    always @(negedge clock) begin
        if (!reset && command_valid && frame_error) begin
            n_errors++;
            $display("FAIL pulse_excl: command_valid=%b frame_error=%b required not both", command_valid, frame_error);
        end
    end

endmodule
